// File: rtl/clock_phase_meter_if.sv
// rtl/clock_phase_meter_if.sv - clock inputs and measurement results of clock_phase_meter
interface clock_phase_meter_if #(
    parameter int CW = 16
);
    logic          en;
    logic          ref_in;
    logic          buf_in;
    logic [CW-1:0] period_o;
    logic [CW-1:0] delay_o;
    logic [8:0]    phase_o;
    logic          valid_o;
    logic          nolock_o;
    logic          timeout_o;
    logic          busy_o;

    // Side that drives the clocks and consumes the results
    modport master (
        output en, ref_in, buf_in,
        input  period_o, delay_o, phase_o, valid_o, nolock_o, timeout_o, busy_o
    );

    // The meter itself
    modport slave (
        input  en, ref_in, buf_in,
        output period_o, delay_o, phase_o, valid_o, nolock_o, timeout_o, busy_o
    );
endinterface

// File: rtl/clock_phase_meter.sv
// rtl/clock_phase_meter.sv - ref period / ref->buf delay / phase monitor
module clock_phase_meter #(
    parameter int CW   = 16,
    parameter int SYNC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    clock_phase_meter_if.slave io
);

    // Numerator dly*360 needs 9 extra bits; one quotient bit per DIV cycle.
    localparam int NW = CW + 9;
    localparam int BW = $clog2(NW);
    // Last count value before the period counter would saturate.
    localparam logic [CW-1:0] CNT_LAST = {{(CW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        MEAS = 2'd1,
        DIV  = 2'd2
    } state_t;

    logic [SYNC-1:0] ref_sync_q, ref_sync_d;
    logic [SYNC-1:0] buf_sync_q, buf_sync_d;
    logic            ref_hist_q, ref_hist_d;
    logic            buf_hist_q, buf_hist_d;
    logic            ref_rise, buf_rise;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   dly_q, dly_d;
    logic [CW-1:0]   per_q, per_d;
    logic            got_buf_q, got_buf_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [NW-1:0]   quo_q, quo_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;

    logic [CW-1:0]   period_q, period_d;
    logic [CW-1:0]   delay_q, delay_d;
    logic [8:0]      phase_q, phase_d;
    logic            valid_q, valid_d;
    logic            nolock_q, nolock_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;

    logic [CW:0]     trial;
    logic            trial_ge;
    logic [CW-1:0]   rem_next;
    logic [NW-1:0]   quo_next;

    // Synchronizer chains plus history flops; both paths have equal latency.
    always_comb begin
        ref_sync_d = {ref_sync_q[SYNC-2:0], io.ref_in};
        buf_sync_d = {buf_sync_q[SYNC-2:0], io.buf_in};
        ref_hist_d = ref_sync_q[SYNC-1];
        buf_hist_d = buf_sync_q[SYNC-1];
    end

    assign ref_rise = ref_sync_q[SYNC-1] & ~ref_hist_q;
    assign buf_rise = buf_sync_q[SYNC-1] & ~buf_hist_q;

    // One restoring-division step: shift next numerator bit into the remainder.
    always_comb begin
        trial    = {rem_q, quo_q[NW-1]};
        trial_ge = (trial >= {1'b0, per_q});
        rem_next = trial_ge ? CW'(trial - {1'b0, per_q}) : trial[CW-1:0];
        quo_next = {quo_q[NW-2:0], trial_ge};
    end

    // Measurement FSM: SEEK -> MEAS -> DIV -> SEEK, all outputs registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        per_d     = per_q;
        got_buf_d = got_buf_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bit_cnt_d = bit_cnt_q;
        period_d  = period_q;
        delay_d   = delay_q;
        phase_d   = phase_q;
        valid_d   = 1'b0;
        nolock_d  = 1'b0;
        timeout_d = 1'b0;

        if (!io.en) begin
            state_d = SEEK;
        end else begin
            case (state_q)
                SEEK: begin
                    // A buf rise in this same cycle is deliberately not captured.
                    if (ref_rise) begin
                        cnt_d     = CW'(1);
                        got_buf_d = 1'b0;
                        state_d   = MEAS;
                    end
                end
                MEAS: begin
                    cnt_d = cnt_q + CW'(1);
                    if (ref_rise) begin
                        // Closing edge; cnt_q equals cycles since the opening edge.
                        per_d = cnt_q;
                        if (got_buf_q) begin
                            quo_d     = NW'(dly_q) * NW'(360);
                            rem_d     = '0;
                            bit_cnt_d = BW'(NW - 1);
                            state_d   = DIV;
                        end else begin
                            nolock_d = 1'b1;
                            state_d  = SEEK;
                        end
                    end else begin
                        // Only the first buf rise of the period defines the delay.
                        if (buf_rise && !got_buf_q) begin
                            dly_d     = cnt_q;
                            got_buf_d = 1'b1;
                        end
                        if (cnt_q == CNT_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = SEEK;
                        end
                    end
                end
                DIV: begin
                    rem_d     = rem_next;
                    quo_d     = quo_next;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    // Final quotient bit is folded straight into the published phase.
                    if (bit_cnt_q == '0) begin
                        period_d = per_q;
                        delay_d  = dly_q;
                        phase_d  = quo_next[8:0];
                        valid_d  = 1'b1;
                        state_d  = SEEK;
                    end
                end
                default: begin
                    state_d = SEEK;
                end
            endcase
        end

        busy_d = (state_d != SEEK);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q <= '0;
            buf_sync_q <= '0;
            ref_hist_q <= 1'b0;
            buf_hist_q <= 1'b0;
            state_q    <= SEEK;
            cnt_q      <= '0;
            dly_q      <= '0;
            per_q      <= '0;
            got_buf_q  <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            bit_cnt_q  <= '0;
            period_q   <= '0;
            delay_q    <= '0;
            phase_q    <= '0;
            valid_q    <= 1'b0;
            nolock_q   <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ref_sync_q <= ref_sync_d;
            buf_sync_q <= buf_sync_d;
            ref_hist_q <= ref_hist_d;
            buf_hist_q <= buf_hist_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            per_q      <= per_d;
            got_buf_q  <= got_buf_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            bit_cnt_q  <= bit_cnt_d;
            period_q   <= period_d;
            delay_q    <= delay_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            nolock_q   <= nolock_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign io.period_o  = period_q;
    assign io.delay_o   = delay_q;
    assign io.phase_o   = phase_q;
    assign io.valid_o   = valid_q;
    assign io.nolock_o  = nolock_q;
    assign io.timeout_o = timeout_q;
    assign io.busy_o    = busy_q;

endmodule
